calc_ctrl_gen: RTL and testbench
================================

# calc_ctrl_gen

Parametrised general controller for the signed calculator. It assembles decimal operands from keypad events and sequences the ALU through a start/done handshake. Each successful result is logged into a circular history memory, and the block drives the display. Over the previous controller it adds generic width, chained and repeat-equals operation, divide-by-zero and overflow error handling, an ALU timeout, and history wrap-around. It sits between the keypad/button debouncers and the ALU, history RAM and display driver.

## Interface
- WIDTH, 16, operand/result width (signed two's complement)
- HIST_DEPTH, 16, history entries; power of two; ADDR_W = $clog2(HIST_DEPTH)
- ALU_TIMEOUT, 255, max cycles to wait for alu_done

Ports:
- clk  in  1  system clock; everything below is clocked on its rising edge
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle pulse: a digit key was pressed
- key_digit  in  4  digit value; values above 9 are ignored
- key_neg  in  1  one-cycle pulse: negate the current entry
- op_valid  in  1  one-cycle pulse: an operator key was pressed
- op_code  in  2  00 add, 01 sub, 10 mul, 11 div
- equal_valid  in  1  one-cycle pulse: '=' was pressed
- clear  in  1  one-cycle pulse: clear everything, including the error state
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  2  ALU operation
- alu_start  out  1  one-cycle start pulse
- alu_done  in  1  one-cycle result-valid pulse
- alu_result  in  WIDTH  ALU result
- alu_ovf  in  1  overflow flag, valid together with alu_done
- mem_we  out  1  history write strobe
- mem_addr  out  ADDR_W  history write address
- mem_wdata  out  WIDTH  history write data
- hist_count  out  ADDR_W+1  number of valid history entries; saturates at HIST_DEPTH
- display_value  out  WIDTH  value shown on the display
- busy  out  1  high in CALC and WRITE
- error  out  1  high in ERR

## Operation
- States: ENTER_A, ENTER_B, CALC, WRITE, SHOW, ERR. Reset and clear both go to ENTER_A.
- Reset values: every output is 0. Internal state: entry magnitude 0, sign 0, A=B=0, last_op=00, wr_ptr=0.
- Input priority when several pulses arrive in one cycle: clear > equal_valid > op_valid > key_neg > key_valid. Only the highest-priority pulse is acted on.
- Digit entry:
  - new magnitude = mag*10 + digit, computed in WIDTH+4 bits.
  - If the new magnitude exceeds 2^(WIDTH-1)-1, the digit is dropped.
  - key_neg toggles the sign flag.
  - Entry value = sign ? -mag : mag.
- ENTER_A:
  - Digits and key_neg edit A.
  - op_valid latches op_code into last_op, clears the entry, and moves to ENTER_B.
  - equal_valid is ignored.
- ENTER_B:
  - Digits and key_neg edit B.
  - op_valid only replaces last_op.
  - equal_valid goes to CALC.
  - If last_op=11 and B=0, equal_valid goes directly to ERR; no alu_start is issued.
- CALC:
  - alu_a=A, alu_b=B and alu_op=last_op are held stable for the whole state.
  - alu_start pulses in the first CALC cycle only.
  - On alu_done with alu_ovf=1, go to ERR.
  - On alu_done with alu_ovf=0, latch R=alu_result and go to WRITE.
  - If ALU_TIMEOUT cycles pass without alu_done, go to ERR.
- WRITE (one cycle):
  - mem_we=1, mem_addr=wr_ptr, mem_wdata=R.
  - wr_ptr increments and wraps from HIST_DEPTH-1 to 0.
  - hist_count increments, saturating at HIST_DEPTH.
  - Next state is SHOW.
- SHOW:
  - op_valid: A=R, last_op=op_code, clear entry, go to ENTER_B (chaining).
  - equal_valid: A=R, B unchanged, go to CALC (repeat-equals). The divide-by-zero check applies here too.
  - key_valid: start a new A entry from that digit, go to ENTER_A.
  - key_neg: ignored.
- ERR:
  - display_value=0, error=1.
  - Only clear (or reset) exits. History contents and hist_count are preserved.
- display_value: the current entry in ENTER_A/ENTER_B (the entry is 0 immediately after an operator); A during CALC; R in WRITE and SHOW.
- Every keypad, operator and equal pulse is ignored while busy=1.

## Timing
- All inputs are sampled at a clock edge; outputs reflect the event from the next cycle on.
- equal_valid in cycle N (state ENTER_B or SHOW): state=CALC and alu_start=1 in cycle N+1.
- alu_done in cycle M: state=WRITE and mem_we=1 in cycle M+1; SHOW and display_value=R in cycle M+2.
- Minimum equal-to-display latency is 3 cycles, reached when alu_done arrives in the first CALC cycle.
- The timeout counter starts at 0 in the first CALC cycle. ERR is entered on the cycle after the counter reaches ALU_TIMEOUT.
- alu_done arriving outside CALC is ignored.
- Reset or clear asserted during CALC: go to ENTER_A next cycle. No mem_we is issued; a later stray alu_done is ignored.
- Reset clears the history pointers. clear does not clear wr_ptr or hist_count.

## Test plan
- Basic add (WIDTH=16): keys 1,2 then op 00 then 3,4 then '='; ALU model returns 46 after 2 cycles. Expect alu_a=12, alu_b=34, a single alu_start pulse, then mem_we with addr 0, data 46, display 46, hist_count=1.
- Entry clamp and sign: keys 3,2,7,6,7,8 then key_neg. Expect display 32767 then -32767; the digit 8 is dropped.
- Chain and repeat: 5 op 00 3 '=' gives 8; op 01, 2, '=' gives 6; '=' gives 4; '=' gives 2. Expect history addrs 0..3 holding 8, 6, 4, 2.
- Divide by zero and overflow: 7 op 11 0 '=' gives error=1 with no alu_start and no mem_we. clear returns to ENTER_A. A forced alu_ovf also gives ERR.
- History wrap (HIST_DEPTH=4): five calculations. The fifth write goes to addr 0; hist_count holds at 4.
- Timeout and reset mid-op: ALU_TIMEOUT=8 with alu_done never asserted gives error=1 in the 9th cycle after CALC entry. A separate run asserts reset in the second CALC cycle: all outputs 0 next cycle, and a late alu_done produces no mem_we.

Source files
------------

// File: rtl/calc_ctrl_gen_if.sv
// Bundle of keypad, ALU, history-memory and display signals for the calculator controller.
// The master modport is the controller; the slave modport is its environment.
interface calc_ctrl_gen_if #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 16
);
    localparam int ADDR_W = $clog2(HIST_DEPTH);

    logic              key_valid;
    logic [3:0]        key_digit;
    logic              key_neg;
    logic              op_valid;
    logic [1:0]        op_code;
    logic              equal_valid;
    logic              clear;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [1:0]        alu_op;
    logic              alu_start;
    logic              alu_done;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_ovf;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [ADDR_W:0]   hist_count;
    logic [WIDTH-1:0]  display_value;
    logic              busy;
    logic              error;

    modport master (
        input  key_valid, key_digit, key_neg, op_valid, op_code, equal_valid, clear,
        input  alu_done, alu_result, alu_ovf,
        output alu_a, alu_b, alu_op, alu_start,
        output mem_we, mem_addr, mem_wdata, hist_count,
        output display_value, busy, error
    );

    modport slave (
        output key_valid, key_digit, key_neg, op_valid, op_code, equal_valid, clear,
        output alu_done, alu_result, alu_ovf,
        input  alu_a, alu_b, alu_op, alu_start,
        input  mem_we, mem_addr, mem_wdata, hist_count,
        input  display_value, busy, error
    );
endinterface

// File: rtl/calc_ctrl_gen.sv
// Signed calculator controller: decimal entry, ALU start/done sequencing with timeout,
// circular result history and display selection.
module calc_ctrl_gen #(
    parameter int WIDTH       = 16,
    parameter int HIST_DEPTH  = 16,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    calc_ctrl_gen_if.master  bus
);
    localparam int ADDR_W  = $clog2(HIST_DEPTH);
    localparam int TIMER_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [WIDTH+3:0] MAX_MAG = {5'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {ENTER_A, ENTER_B, CALC, WRITE, SHOW, ERR} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [WIDTH-1:0]    r_mag;
    logic                r_sign;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_r;
    logic [1:0]          r_op;
    logic [TIMER_W-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_wrPtr;
    logic [ADDR_W:0]     r_histCount;

    logic                w_busy;
    logic                w_eq;
    logic                w_op;
    logic                w_neg;
    logic                w_key;
    logic                w_digitOk;
    logic                w_digitAccept;
    logic [WIDTH+3:0]    w_newMag;
    logic [WIDTH-1:0]    w_entry;
    logic [WIDTH-1:0]    w_aluA;
    logic [WIDTH-1:0]    w_aluB;
    logic [1:0]          w_aluOp;
    logic                w_aluStart;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [WIDTH-1:0]    w_memWdata;
    logic [WIDTH-1:0]    w_display;

    assign w_busy = (r_state == CALC) || (r_state == WRITE);

    // Only the highest-priority pulse survives; keypad pulses are dead while busy.
    assign w_eq  = bus.equal_valid & ~bus.clear & ~w_busy;
    assign w_op  = bus.op_valid & ~bus.equal_valid & ~bus.clear & ~w_busy;
    assign w_neg = bus.key_neg & ~bus.op_valid & ~bus.equal_valid & ~bus.clear & ~w_busy;
    assign w_key = bus.key_valid & ~bus.key_neg & ~bus.op_valid & ~bus.equal_valid
                   & ~bus.clear & ~w_busy;

    assign w_digitOk     = (bus.key_digit <= 4'd9);
    assign w_newMag      = {4'b0, r_mag} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, bus.key_digit};
    assign w_digitAccept = w_key && w_digitOk && (w_newMag <= MAX_MAG);
    assign w_entry       = r_sign ? (~r_mag + WIDTH'(1)) : r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ENTER_A;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_aluA      = '0;
        w_aluB      = '0;
        w_aluOp     = 2'b00;
        w_aluStart  = 1'b0;
        w_memWe     = 1'b0;
        w_memAddr   = '0;
        w_memWdata  = '0;
        w_display   = '0;
        case (r_state)
            ENTER_A: begin
                w_display = w_entry;
                if (w_op) w_nextState = ENTER_B;
            end
            ENTER_B: begin
                w_display = w_entry;
                if (w_eq) w_nextState = (r_op == 2'b11 && w_entry == '0) ? ERR : CALC;
            end
            CALC: begin
                w_aluA     = r_a;
                w_aluB     = r_b;
                w_aluOp    = r_op;
                w_aluStart = (r_timer == '0);
                w_display  = r_a;
                if (bus.alu_done) begin
                    w_nextState = bus.alu_ovf ? ERR : WRITE;
                end else if (r_timer == TIMER_W'(ALU_TIMEOUT)) begin
                    w_nextState = ERR;
                end
            end
            WRITE: begin
                w_memWe     = 1'b1;
                w_memAddr   = r_wrPtr;
                w_memWdata  = r_r;
                w_display   = r_r;
                w_nextState = SHOW;
            end
            SHOW: begin
                w_display = r_r;
                if (w_op) begin
                    w_nextState = ENTER_B;
                end else if (w_eq) begin
                    w_nextState = (r_op == 2'b11 && r_b == '0) ? ERR : CALC;
                end else if (w_key && w_digitOk) begin
                    w_nextState = ENTER_A;
                end
            end
            ERR: begin
                w_nextState = ERR;
            end
            default: w_nextState = ENTER_A;
        endcase
        if (bus.clear) w_nextState = ENTER_A;
    end

    // Datapath: clear wipes the calculation but deliberately keeps the history pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag       <= '0;
            r_sign      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_r         <= '0;
            r_op        <= 2'b00;
            r_timer     <= '0;
            r_wrPtr     <= '0;
            r_histCount <= '0;
        end else if (bus.clear) begin
            r_mag   <= '0;
            r_sign  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_op    <= 2'b00;
            r_timer <= '0;
        end else begin
            r_timer <= '0;
            case (r_state)
                ENTER_A: begin
                    if (w_op) begin
                        r_a    <= w_entry;
                        r_op   <= bus.op_code;
                        r_mag  <= '0;
                        r_sign <= 1'b0;
                    end else if (w_neg) begin
                        r_sign <= ~r_sign;
                    end else if (w_digitAccept) begin
                        r_mag <= w_newMag[WIDTH-1:0];
                    end
                end
                ENTER_B: begin
                    if (w_eq) begin
                        r_b    <= w_entry;
                        r_mag  <= '0;
                        r_sign <= 1'b0;
                    end else if (w_op) begin
                        r_op <= bus.op_code;
                    end else if (w_neg) begin
                        r_sign <= ~r_sign;
                    end else if (w_digitAccept) begin
                        r_mag <= w_newMag[WIDTH-1:0];
                    end
                end
                CALC: begin
                    if (bus.alu_done) begin
                        if (!bus.alu_ovf) r_r <= bus.alu_result;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                WRITE: begin
                    r_wrPtr <= r_wrPtr + ADDR_W'(1);
                    if (r_histCount != (ADDR_W+1)'(HIST_DEPTH)) begin
                        r_histCount <= r_histCount + (ADDR_W+1)'(1);
                    end
                end
                SHOW: begin
                    if (w_op) begin
                        r_a    <= r_r;
                        r_op   <= bus.op_code;
                        r_mag  <= '0;
                        r_sign <= 1'b0;
                    end else if (w_eq) begin
                        r_a <= r_r;
                    end else if (w_key && w_digitOk) begin
                        r_mag  <= {{(WIDTH-4){1'b0}}, bus.key_digit};
                        r_sign <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a         = w_aluA;
    assign bus.alu_b         = w_aluB;
    assign bus.alu_op        = w_aluOp;
    assign bus.alu_start     = w_aluStart;
    assign bus.mem_we        = w_memWe;
    assign bus.mem_addr      = w_memAddr;
    assign bus.mem_wdata     = w_memWdata;
    assign bus.hist_count    = r_histCount;
    assign bus.display_value = w_display;
    assign bus.busy          = w_busy;
    assign bus.error         = (r_state == ERR);
endmodule

// File: tb/tb_calc_ctrl_gen.sv
// Directed bench for calc_ctrl_gen with a small latency-programmable ALU responder.
module tb_calc_ctrl_gen;
    localparam int WIDTH       = 16;
    localparam int HIST_DEPTH  = 4;
    localparam int ALU_TIMEOUT = 8;

    typedef enum {EV_KEY, EV_NEG, EV_OP, EV_EQ, EV_CLR} ev_t;

    logic clk;
    logic reset;
    int   checks     = 0;
    int   errors     = 0;
    int   startCount = 0;
    int   memWeCount = 0;
    int   aluLatency = 1;
    bit   aluEnable  = 1'b1;
    bit   forceOvf   = 1'b0;

    calc_ctrl_gen_if #(.WIDTH(WIDTH), .HIST_DEPTH(HIST_DEPTH)) bus ();

    calc_ctrl_gen #(
        .WIDTH(WIDTH),
        .HIST_DEPTH(HIST_DEPTH),
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(negedge clk) begin
        if (bus.alu_start === 1'b1) startCount++;
        if (bus.mem_we === 1'b1) memWeCount++;
    end

    // ALU responder: captures operands mid-cycle, answers aluLatency cycles later.
    initial begin
        logic signed [WIDTH-1:0] a;
        logic signed [WIDTH-1:0] b;
        logic signed [WIDTH-1:0] res;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        bus.alu_ovf    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start === 1'b1 && aluEnable) begin
                a = bus.alu_a;
                b = bus.alu_b;
                case (bus.alu_op)
                    2'b00: res = a + b;
                    2'b01: res = a - b;
                    2'b10: res = a * b;
                    default: res = (b == 0) ? '0 : a / b;
                endcase
                repeat (aluLatency) @(posedge clk);
                #1;
                bus.alu_done   = 1'b1;
                bus.alu_result = res;
                bus.alu_ovf    = forceOvf;
                @(posedge clk);
                #1;
                bus.alu_done = 1'b0;
                bus.alu_ovf  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input ev_t ev, input logic [3:0] val = 4'd0);
        case (ev)
            EV_KEY: begin bus.key_valid = 1'b1; bus.key_digit = val; end
            EV_NEG: bus.key_neg = 1'b1;
            EV_OP:  begin bus.op_valid = 1'b1; bus.op_code = val[1:0]; end
            EV_EQ:  bus.equal_valid = 1'b1;
            default: bus.clear = 1'b1;
        endcase
        tick();
        bus.key_valid   = 1'b0;
        bus.key_neg     = 1'b0;
        bus.op_valid    = 1'b0;
        bus.equal_valid = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic keyNumber(input int n);
        int d[$];
        int v;
        v = n;
        if (v == 0) d.push_front(0);
        while (v > 0) begin
            d.push_front(v % 10);
            v = v / 10;
        end
        foreach (d[i]) applyStimulus(EV_KEY, 4'(d[i]));
    endtask

    function automatic logic signed [31:0] dispVal();
        return 32'($signed(bus.display_value));
    endfunction

    // Waits (bounded) for the history write, checks it, then checks the SHOW display.
    task automatic waitWrite(input string tag, input int expAddr, input int expData,
                             output int cycles);
        int n;
        n = 0;
        while (bus.mem_we !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        cycles = n;
        checkOutput({tag, "_we"}, bus.mem_we, 1);
        checkOutput({tag, "_addr"}, bus.mem_addr, expAddr);
        checkOutput({tag, "_data"}, 32'($signed(bus.mem_wdata)), expData);
        tick();
        checkOutput({tag, "_disp"}, dispVal(), expData);
    endtask

    initial begin
        int s0;
        int m0;
        int n;
        bus.key_valid   = 1'b0;
        bus.key_digit   = 4'd0;
        bus.key_neg     = 1'b0;
        bus.op_valid    = 1'b0;
        bus.op_code     = 2'b00;
        bus.equal_valid = 1'b0;
        bus.clear       = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_error", bus.error, 0);
        checkOutput("rst_start", bus.alu_start, 0);
        checkOutput("rst_alu_a", bus.alu_a, 0);
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_hist", bus.hist_count, 0);
        checkOutput("rst_disp", dispVal(), 0);

        // Basic add: 12 + 34 with a two-cycle ALU.
        aluLatency = 2;
        s0 = startCount;
        keyNumber(12);
        checkOutput("add_entry_a", dispVal(), 12);
        applyStimulus(EV_OP, 4'd0);
        checkOutput("add_entry_cleared", dispVal(), 0);
        keyNumber(34);
        checkOutput("add_entry_b", dispVal(), 34);
        applyStimulus(EV_EQ);
        checkOutput("add_start", bus.alu_start, 1);
        checkOutput("add_busy", bus.busy, 1);
        checkOutput("add_alu_a", bus.alu_a, 12);
        checkOutput("add_alu_b", bus.alu_b, 34);
        checkOutput("add_alu_op", bus.alu_op, 0);
        tick();
        checkOutput("add_start_once", bus.alu_start, 0);
        checkOutput("add_alu_a_held", bus.alu_a, 12);
        waitWrite("add", 0, 46, n);
        checkOutput("add_write_latency", n, 2);
        checkOutput("add_hist", bus.hist_count, 1);
        checkOutput("add_start_count", startCount - s0, 1);

        // Entry clamp and sign, entered straight from SHOW.
        keyNumber(32767);
        checkOutput("clamp_max", dispVal(), 32767);
        applyStimulus(EV_KEY, 4'd8);
        checkOutput("clamp_drop", dispVal(), 32767);
        applyStimulus(EV_NEG);
        checkOutput("clamp_neg", dispVal(), -32767);
        applyStimulus(EV_CLR);
        checkOutput("clear_disp", dispVal(), 0);
        checkOutput("clear_keeps_hist", bus.hist_count, 1);

        // Chain, repeat-equals and history wrap.
        aluLatency = 1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("chain_rst_hist", bus.hist_count, 0);
        keyNumber(5);
        applyStimulus(EV_OP, 4'd0);
        keyNumber(3);
        applyStimulus(EV_EQ);
        waitWrite("chain0", 0, 8, n);
        applyStimulus(EV_OP, 4'd1);
        checkOutput("chain_entry_cleared", dispVal(), 0);
        keyNumber(2);
        applyStimulus(EV_EQ);
        checkOutput("chain_alu_a", bus.alu_a, 8);
        waitWrite("chain1", 1, 6, n);
        applyStimulus(EV_EQ);
        checkOutput("repeat_alu_a", bus.alu_a, 6);
        checkOutput("repeat_alu_b", bus.alu_b, 2);
        waitWrite("repeat2", 2, 4, n);
        applyStimulus(EV_EQ);
        waitWrite("repeat3", 3, 2, n);
        checkOutput("hist_full", bus.hist_count, 4);
        applyStimulus(EV_EQ);
        waitWrite("wrap", 0, 0, n);
        checkOutput("hist_sat", bus.hist_count, 4);

        // Divide by zero: no start, no write, only clear leaves.
        applyStimulus(EV_CLR);
        s0 = startCount;
        m0 = memWeCount;
        keyNumber(7);
        applyStimulus(EV_OP, 4'd3);
        keyNumber(0);
        applyStimulus(EV_EQ);
        checkOutput("dz_error", bus.error, 1);
        checkOutput("dz_busy", bus.busy, 0);
        checkOutput("dz_disp", dispVal(), 0);
        tick();
        tick();
        checkOutput("dz_no_start", startCount - s0, 0);
        checkOutput("dz_no_write", memWeCount - m0, 0);
        checkOutput("dz_hist_kept", bus.hist_count, 4);
        applyStimulus(EV_KEY, 4'd5);
        checkOutput("err_sticky", bus.error, 1);
        checkOutput("err_disp", dispVal(), 0);
        applyStimulus(EV_CLR);
        checkOutput("err_cleared", bus.error, 0);

        // ALU overflow goes to ERR without a history write.
        forceOvf = 1'b1;
        m0 = memWeCount;
        keyNumber(9);
        applyStimulus(EV_OP, 4'd2);
        keyNumber(9);
        applyStimulus(EV_EQ);
        n = 0;
        while (bus.error !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("ovf_error", bus.error, 1);
        checkOutput("ovf_no_write", memWeCount - m0, 0);
        forceOvf = 1'b0;
        applyStimulus(EV_CLR);

        // Timeout: ALU never answers, ERR appears 9 cycles after CALC entry.
        aluEnable = 1'b0;
        keyNumber(1);
        applyStimulus(EV_OP, 4'd0);
        keyNumber(1);
        applyStimulus(EV_EQ);
        checkOutput("to_calc", bus.busy, 1);
        n = 0;
        while (bus.error !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checkOutput("to_cycles", n, 9);
        applyStimulus(EV_CLR);
        aluEnable = 1'b1;

        // Reset in the second CALC cycle; the late alu_done must be ignored.
        aluLatency = 4;
        keyNumber(2);
        applyStimulus(EV_OP, 4'd0);
        keyNumber(2);
        applyStimulus(EV_EQ);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_alu_a", bus.alu_a, 0);
        checkOutput("mid_rst_hist", bus.hist_count, 0);
        checkOutput("mid_rst_disp", dispVal(), 0);
        m0 = memWeCount;
        repeat (6) tick();
        checkOutput("late_done_no_write", memWeCount - m0, 0);
        checkOutput("late_done_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
